// File: rtl/scene_sequencer.sv
// Day/night scene sequencer: moves a sun across the screen once per "tick",
// where a tick is every (speed+1)th frame_start pulse, cycling DAWN/DAY/DUSK/NIGHT.
module scene_sequencer #(
  parameter int X_START     = 0,
  parameter int Y_LOW       = 920,
  parameter int Y_HIGH      = 200,
  parameter int STEP_X      = 8,
  parameter int STEP_Y      = 8,
  parameter int X_DUSK      = 1000,
  parameter int NIGHT_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        enable,
  input  logic        restart,
  input  logic [3:0]  speed,
  output logic [11:0] sun_x,
  output logic [11:0] sun_y,
  output logic        sun_visible,
  output logic [11:0] sky_colour,
  output logic [1:0]  phase
);

  localparam int NW = (NIGHT_TICKS > 2) ? $clog2(NIGHT_TICKS) : 1;
  localparam logic [NW-1:0] NIGHT_LAST = NW'(NIGHT_TICKS - 1);

  typedef enum logic [1:0] {
    DAWN  = 2'd0,
    DAY   = 2'd1,
    DUSK  = 2'd2,
    NIGHT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      div_q, div_d;
  logic [NW-1:0]   night_q, night_d;
  logic [11:0]     x_q, x_d, y_q, y_d, sky_q, sky_d;
  logic            vis_q, vis_d;
  logic [12:0]     x_sum, y_up;
  logic [11:0]     x_sat;
  logic            tick;

  function automatic logic [11:0] skyOf(state_e s);
    case (s)
      DAWN:    return 12'hF80;
      DAY:     return 12'h00F;
      DUSK:    return 12'hF40;
      default: return 12'h002;
    endcase
  endfunction

  // count >= speed (not ==) so a speed lowered below the current count ticks at once
  assign tick  = enable && frame_start && (div_q >= speed);
  assign x_sum = {1'b0, x_q} + 13'(STEP_X);
  assign x_sat = x_sum[12] ? 12'hFFF : x_sum[11:0];
  assign y_up  = {1'b0, y_q} + 13'(STEP_Y);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    night_d = night_q;
    x_d     = x_q;
    y_d     = y_q;

    if (restart) begin
      state_d = DAWN;
      div_d   = '0;
      night_d = '0;
      x_d     = 12'(X_START);
      y_d     = 12'(Y_LOW);
    end else if (enable && frame_start) begin
      if (!tick) begin
        div_d = div_q + 4'd1;
      end else begin
        div_d = '0;
        case (state_q)
          DAWN: begin
            x_d = x_sat;
            if ({2'b00, y_q} <= 14'(Y_HIGH) + 14'(STEP_Y)) begin
              y_d     = 12'(Y_HIGH);
              state_d = DAY;
            end else begin
              y_d = y_q - 12'(STEP_Y);
            end
          end
          DAY: begin
            x_d = x_sat;
            if ({1'b0, x_sat} >= 13'(X_DUSK)) state_d = DUSK;
          end
          DUSK: begin
            x_d = x_sat;
            if (y_up >= 13'(Y_LOW)) begin
              y_d     = 12'(Y_LOW);
              state_d = NIGHT;
              night_d = '0;
            end else begin
              y_d = y_up[11:0];
            end
          end
          default: begin
            if (night_q == NIGHT_LAST) begin
              x_d     = 12'(X_START);
              y_d     = 12'(Y_LOW);
              state_d = DAWN;
              night_d = '0;
            end else begin
              night_d = night_q + 1'b1;
            end
          end
        endcase
      end
    end

    sky_d = skyOf(state_d);
    vis_d = (state_d != NIGHT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DAWN;
      div_q   <= '0;
      night_q <= '0;
      x_q     <= 12'(X_START);
      y_q     <= 12'(Y_LOW);
      sky_q   <= 12'hF80;
      vis_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      night_q <= night_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sky_q   <= sky_d;
      vis_q   <= vis_d;
    end
  end

  assign sun_x       = x_q;
  assign sun_y       = y_q;
  assign sun_visible = vis_q;
  assign sky_colour  = sky_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Bench for scene_sequencer: a tick-position model gives the expected scene in
// closed form, checked every cycle, plus hand-computed literal checkpoints.
module tb_scene_sequencer;

  localparam int X_START = 0, Y_LOW = 920, Y_HIGH = 200, STEP_X = 8, STEP_Y = 8;
  localparam int X_DUSK = 1000, NIGHT_TICKS = 16;
  localparam int DAWN_END = (Y_LOW - Y_HIGH) / STEP_Y;
  localparam int DAY_END  = (X_DUSK + STEP_X - 1) / STEP_X;
  localparam int DUSK_END = DAY_END + (Y_LOW - Y_HIGH) / STEP_Y;
  localparam int CYCLE    = DUSK_END + NIGHT_TICKS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0, enable = 1'b0, restart = 1'b0;
  logic [3:0]  speed = 4'd0;
  logic [11:0] sun_x, sun_y, sky_colour;
  logic        sun_visible;
  logic [1:0]  phase;

  int vectors = 0, miscompares = 0;
  int modelPos = 0, modelDiv = 0;
  bit checkEn = 1'b0;

  scene_sequencer #(
    .X_START(X_START), .Y_LOW(Y_LOW), .Y_HIGH(Y_HIGH), .STEP_X(STEP_X),
    .STEP_Y(STEP_Y), .X_DUSK(X_DUSK), .NIGHT_TICKS(NIGHT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable),
    .restart(restart), .speed(speed), .sun_x(sun_x), .sun_y(sun_y),
    .sun_visible(sun_visible), .sky_colour(sky_colour), .phase(phase)
  );

  always #5 clk = ~clk;

  // Scene as a function of how many ticks have elapsed since dawn
  function automatic logic [1:0] expPhase(int q);
    if (q < DAWN_END) return 2'd0;
    if (q < DAY_END)  return 2'd1;
    if (q < DUSK_END) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [11:0] expX(int q);
    return (q < DUSK_END) ? 12'(X_START + STEP_X * q) : 12'(X_START + STEP_X * DUSK_END);
  endfunction

  function automatic logic [11:0] expY(int q);
    if (q < DAWN_END) return 12'(Y_LOW - STEP_Y * q);
    if (q < DAY_END)  return 12'(Y_HIGH);
    if (q < DUSK_END) return 12'(Y_HIGH + STEP_Y * (q - DAY_END));
    return 12'(Y_LOW);
  endfunction

  function automatic logic [11:0] expSky(int q);
    logic [11:0] table4 [4] = '{12'hF80, 12'h00F, 12'hF40, 12'h002};
    return table4[expPhase(q)];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || restart) begin
      modelPos <= 0;
      modelDiv <= 0;
    end else if (enable && frame_start) begin
      if (modelDiv >= int'(speed)) begin
        modelDiv <= 0;
        modelPos <= (modelPos + 1) % CYCLE;
      end else begin
        modelDiv <= modelDiv + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      logic [38:0] act, exp;
      act = {sun_x, sun_y, sun_visible, sky_colour, phase};
      exp = {expX(modelPos), expY(modelPos), expPhase(modelPos) != 2'd3,
             expSky(modelPos), expPhase(modelPos)};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL cycleModel t=%0t pos=%0d got x=%0d y=%0d vis=%0b sky=%h ph=%0d want x=%0d y=%0d vis=%0b sky=%h ph=%0d",
                 $time, modelPos, sun_x, sun_y, sun_visible, sky_colour, phase,
                 exp[38:27], exp[26:15], exp[14], exp[13:2], exp[1:0]);
      end
    end
  end

  task automatic applyStimulus(input logic fs, input logic rs);
    @(negedge clk); #1;
    frame_start = fs;
    restart     = rs;
    @(negedge clk); #1;
    frame_start = 1'b0;
    restart     = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0);
      @(negedge clk); #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d (0x%h) want %0d (0x%h)", name, act, act, req, req);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_x"}, sun_x, 12'd0);
    checkOutput({tag, "_y"}, sun_y, 12'd920);
    checkOutput({tag, "_phase"}, {10'd0, phase}, 12'd0);
    checkOutput({tag, "_vis"}, {11'd0, sun_visible}, 12'd1);
    checkOutput({tag, "_sky"}, sky_colour, 12'hF80);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    checkReset("reset");
    rst = 1'b0;
    enable = 1'b1;
    checkEn = 1'b1;

    pulses(90);
    checkOutput("day_x", sun_x, 12'd720);
    checkOutput("day_y", sun_y, 12'd200);
    checkOutput("day_phase", {10'd0, phase}, 12'd1);
    checkOutput("day_sky", sky_colour, 12'h00F);
    pulses(35);
    checkOutput("dusk_x", sun_x, 12'd1000);
    checkOutput("dusk_phase", {10'd0, phase}, 12'd2);
    pulses(90);
    checkOutput("night_x", sun_x, 12'd1720);
    checkOutput("night_y", sun_y, 12'd920);
    checkOutput("night_phase", {10'd0, phase}, 12'd3);
    checkOutput("night_vis", {11'd0, sun_visible}, 12'd0);
    checkOutput("night_sky", sky_colour, 12'h002);
    pulses(16);
    checkReset("dawn1");
    pulses(231);
    checkReset("dawn2");

    speed = 4'd3;
    pulses(8);
    checkOutput("slow_x", sun_x, 12'd16);
    checkOutput("slow_y", sun_y, 12'd904);
    pulses(2);
    enable = 1'b0;
    pulses(10);
    checkOutput("frozen_x", sun_x, 12'd16);
    enable = 1'b1;
    pulses(1);
    checkOutput("held_div_x", sun_x, 12'd16);
    pulses(1);
    checkOutput("resume_x", sun_x, 12'd24);

    pulses(3);
    speed = 4'd1;
    pulses(1);
    checkOutput("speed_drop_x", sun_x, 12'd32);

    speed = 4'd0;
    pulses(90);
    checkOutput("pre_restart_phase", {10'd0, phase}, 12'd1);
    applyStimulus(1'b1, 1'b1);
    checkReset("restart_day");
    pulses(5);
    enable = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkReset("restart_dis");
    enable = 1'b1;

    pulses(130);
    checkOutput("pre_rst_phase", {10'd0, phase}, 12'd2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkReset("async_rst");
    @(negedge clk); #1;
    rst = 1'b0;
    speed = 4'd2;
    pulses(2);
    checkOutput("post_rst_wait_x", sun_x, 12'd0);
    pulses(1);
    checkOutput("post_rst_tick_x", sun_x, 12'd8);

    checkEn = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
